pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-flow controller that drives the ALU's instruction stream. Holds the program counter and runs a small start/run/halt state machine. Each executed instruction it applies the ALU's branch offset/sign, soft-reset and halt outputs to compute the next PC. It sits between instruction memory (addressed by PC) and the ALU/register-file datapath, and gates execution with a one-cycle fetch fill and a memory stall.

## Interface
Parameters:
- PC_W, 10, program counter width; all PC arithmetic is modulo 2^PC_W.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  begin execution at START_ADDR; honoured only in IDLE or HALTED.
- START_ADDR  in  PC_W  entry point, used on START and on soft reset.
- STALL  in  1  memory not ready; hold PC and state.
- BR_EN  in  1  current instruction is a branch op (BRC/BRR/BRO).
- BOFFSET  in  9  unsigned branch magnitude from ALU (bOFFSET).
- BSIGN  in  1  1 = backward (subtract), 0 = forward (add).
- SOFT_RST  in  1  ALU reset output.
- SOFT_HALT  in  1  ALU halt output; meaningful only with SOFT_RST=1.
- PC  out  PC_W  current instruction address.
- INSTR_VALID  out  1  instruction at PC executes this cycle; control inputs are sampled only when high.
- RUNNING  out  1  state is FILL or RUN.
- DONE  out  1  state is HALTED.
- CYCLE_CNT  out  16  executed-instruction count (see Configuration).

## Operation
- States: IDLE, FILL, RUN, HALTED.
- IDLE/HALTED --START--> FILL with PC <= START_ADDR and CYCLE_CNT <= 0.
- FILL -> RUN after exactly one cycle, regardless of STALL; INSTR_VALID=0 in FILL.
- In RUN, INSTR_VALID = !STALL.
- In RUN with INSTR_VALID=1, the first matching rule applies:
  1. SOFT_RST & SOFT_HALT: go to HALTED, PC holds.
  2. SOFT_RST & !SOFT_HALT: PC <= START_ADDR, go to FILL.
  3. BR_EN: PC <= BSIGN ? PC - BOFFSET : PC + BOFFSET. BOFFSET is zero-extended or truncated to PC_W before the add/subtract. A not-taken branch arrives as offset 1, sign 0.
  4. Otherwise: PC <= PC + 1.
- In RUN with STALL=1: PC, state and counter hold; all control inputs are ignored.
- START in RUN or FILL is ignored.
- HALTED holds PC until START.
- Wrap-around: PC arithmetic wraps silently modulo 2^PC_W. Example: PC=0, BSIGN=1, BOFFSET=1 gives PC=2^PC_W-1.
- BOFFSET=0 with BR_EN=1 holds PC (tight loop), stays in RUN.

## Timing
- All outputs are registered except INSTR_VALID, which is combinational from state and STALL.
- Reset values: PC=0, state IDLE, INSTR_VALID=0, RUNNING=0, DONE=0, CYCLE_CNT=0.
- RESET_N asserted mid-operation forces reset values immediately (asynchronously); the first START is accepted on the first rising edge after deassertion.
- START sampled at edge N: PC=START_ADDR and RUNNING=1 after N. First INSTR_VALID=1 occurs in the cycle following edge N+1.
- Next-PC latency: one cycle. Inputs sampled at edge k with INSTR_VALID=1 appear on PC after edge k.
- DONE rises the cycle after the halting instruction's edge.
- Soft reset costs one FILL bubble.

## Configuration
- PC_SEQ_CYCLE_CNT_EN defined:
  - CYCLE_CNT increments by 1 on every edge where INSTR_VALID=1.
  - Saturates at 16'hFFFF.
  - Cleared on START and on RESET_N; soft reset does not clear it.
  - Holds in HALTED.
- Undefined: CYCLE_CNT is tied to 16'h0000 and no counter flops are built.

## Test plan
- Reset, START with START_ADDR=0x010, no branches, 4 cycles: PC 0x010 (FILL), then 0x010, 0x011, 0x012, 0x013; INSTR_VALID=0 only in the FILL cycle.
- At PC=0x020 with BR_EN=1, BSIGN=1, BOFFSET=5 -> PC=0x01B. At PC=0x3FE with BSIGN=0, BOFFSET=3 -> PC=0x001 (wrap, PC_W=10).
- STALL high for 3 cycles at PC=0x005 while BR_EN=1 and SOFT_RST=1 are asserted: PC stays 0x005, state RUN, CYCLE_CNT unchanged. STALL low with plain instruction -> PC=0x006.
- SOFT_RST=1, SOFT_HALT=0 at PC=0x030, START_ADDR=0x008 -> PC=0x008 via one FILL cycle. SOFT_RST=1, SOFT_HALT=1 -> DONE=1, PC frozen, further BR_EN ignored. START then restarts from START_ADDR.
- RESET_N low mid-RUN at PC=0x044, between clock edges: PC=0, DONE=0, RUNNING=0 immediately, before the next edge. START in RUN ignored (PC continues incrementing).
- With PC_SEQ_CYCLE_CNT_EN: 7 executed instructions plus 2 stall cycles -> CYCLE_CNT=7; counter saturates at 0xFFFF. Without the macro: CYCLE_CNT=0 throughout.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller for the ALU instruction stream.
// Holds the program counter and runs an IDLE/FILL/RUN/HALTED state machine.
// Each executed instruction applies the ALU branch offset/sign, soft reset
// and halt outputs to compute the next PC. A one-cycle FILL bubble follows
// every (re)start, and STALL freezes PC, state and counter while in RUN.
//
// Optional feature macro: PC_SEQ_CYCLE_CNT_EN. When defined, cycle_cnt_o is
// a saturating count of executed instructions; otherwise it is tied to zero
// and no counter flops are built.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        begin execution at start_addr_i (only in IDLE/HALTED)
//   start_addr_i   entry point for START and soft reset
//   stall_i        memory not ready; hold everything in RUN
//   br_en_i        current instruction is a branch
//   boffset_i      unsigned branch magnitude
//   bsign_i        1 = backward (subtract), 0 = forward (add)
//   soft_rst_i     ALU soft reset
//   soft_halt_i    ALU halt, qualified by soft_rst_i
//   pc_o           current instruction address
//   instr_valid_o  instruction at pc_o executes this cycle (combinational)
//   running_o      state is FILL or RUN
//   done_o         state is HALTED
//   cycle_cnt_o    executed-instruction count
module pc_sequencer #(
  parameter int unsigned PC_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_addr_i,
  input  logic            stall_i,
  input  logic            br_en_i,
  input  logic [8:0]      boffset_i,
  input  logic            bsign_i,
  input  logic            soft_rst_i,
  input  logic            soft_halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            instr_valid_o,
  output logic            running_o,
  output logic            done_o,
  output logic [15:0]     cycle_cnt_o
);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StHalted} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, done_q;
  logic            instr_valid;
  logic [PC_W-1:0] boff_ext;

  // Zero-extend or truncate the 9-bit offset to the PC width.
  assign boff_ext    = PC_W'(boffset_i);
  assign instr_valid = (state_q == StRun) && !stall_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start_i) begin
          state_d = StFill;
          pc_d    = start_addr_i;
        end
      end
      StFill: state_d = StRun;
      StRun: begin
        if (instr_valid) begin
          if (soft_rst_i && soft_halt_i) begin
            state_d = StHalted;
          end else if (soft_rst_i) begin
            state_d = StFill;
            pc_d    = start_addr_i;
          end else if (br_en_i) begin
            pc_d = bsign_i ? (pc_q - boff_ext) : (pc_q + boff_ext);
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == StFill) || (state_d == StRun);
      done_q    <= (state_d == StHalted);
    end
  end

  assign pc_o          = pc_q;
  assign instr_valid_o = instr_valid;
  assign running_o     = running_q;
  assign done_o        = done_q;

`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        start_ok;

  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StHalted));

  // Cleared only by START; soft reset keeps the running total.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (instr_valid && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_cnt_o = cnt_q;
`else
  assign cycle_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W = 10).
module tb_pc_sequencer;

  localparam int unsigned PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            stall;
  logic            br_en;
  logic [8:0]      boffset;
  logic            bsign;
  logic            soft_rst;
  logic            soft_halt;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic            running;
  logic            done;
  logic [15:0]     cycle_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned exp_cnt = 0;

  pc_sequencer #(.PC_W(PC_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .stall_i      (stall),
    .br_en_i      (br_en),
    .boffset_i    (boffset),
    .bsign_i      (bsign),
    .soft_rst_i   (soft_rst),
    .soft_halt_i  (soft_halt),
    .pc_o         (pc),
    .instr_valid_o(instr_valid),
    .running_o    (running),
    .done_o       (done),
    .cycle_cnt_o  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected counter value for the current build.
  function automatic logic [31:0] cnt_exp();
`ifdef PC_SEQ_CYCLE_CNT_EN
    return 32'(exp_cnt);
`else
    return 32'h0;
`endif
  endfunction

  // exec: the instruction before this edge executes (instr_valid expected 1).
  task automatic step(input bit exec);
    if (exec) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0; br_en = 1'b0;
    boffset = '0; bsign = 1'b0; soft_rst = 1'b0; soft_halt = 1'b0;
    #3;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_iv", 32'(instr_valid), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cnt", 32'(cycle_cnt), 32'h0);
    #9 rst_n = 1'b1;

    // Start at 0x010, straight-line code.
    start_addr = 10'h010; start = 1'b1;
    step(0); exp_cnt = 0;
    start = 1'b0;
    check("fill_pc", 32'(pc), 32'h010);
    check("fill_iv", 32'(instr_valid), 32'h0);
    check("fill_running", 32'(running), 32'h1);
    step(0);
    check("run_pc0", 32'(pc), 32'h010);
    check("run_iv", 32'(instr_valid), 32'h1);
    step(1); check("run_pc1", 32'(pc), 32'h011);
    step(1); check("run_pc2", 32'(pc), 32'h012);
    step(1); check("run_pc3", 32'(pc), 32'h013);
    check("cnt_a", 32'(cycle_cnt), cnt_exp());

    // Branches.
    br_en = 1'b1; bsign = 1'b0; boffset = 9'h00D;
    step(1); check("br_fwd", 32'(pc), 32'h020);
    bsign = 1'b1; boffset = 9'd5;
    step(1); check("br_back", 32'(pc), 32'h01B);
    bsign = 1'b1; boffset = 9'h01D;
    step(1); check("br_back_wrap", 32'(pc), 32'h3FE);
    bsign = 1'b0; boffset = 9'd3;
    step(1); check("br_fwd_wrap", 32'(pc), 32'h001);
    bsign = 1'b0; boffset = 9'h1FF;
    step(1); check("br_max", 32'(pc), 32'h200);
    boffset = 9'd0;
    step(1); check("br_zero_pc", 32'(pc), 32'h200);
    check("br_zero_run", 32'(running), 32'h1);
    bsign = 1'b1; boffset = 9'h1FB;
    step(1); check("br_to_5", 32'(pc), 32'h005);

    // Stall with control inputs asserted: everything holds.
    stall = 1'b1; br_en = 1'b1; soft_rst = 1'b1; soft_halt = 1'b0; boffset = 9'h055;
    #1 check("stall_iv", 32'(instr_valid), 32'h0);
    step(0); step(0); step(0);
    check("stall_pc", 32'(pc), 32'h005);
    check("stall_running", 32'(running), 32'h1);
    check("stall_cnt", 32'(cycle_cnt), cnt_exp());
    stall = 1'b0; br_en = 1'b0; soft_rst = 1'b0;
    step(1); check("unstall_pc", 32'(pc), 32'h006);

    // Soft reset at 0x030 back to 0x008.
    br_en = 1'b1; bsign = 1'b0; boffset = 9'h02A;
    step(1); check("to_30", 32'(pc), 32'h030);
    br_en = 1'b0; soft_rst = 1'b1; soft_halt = 1'b0; start_addr = 10'h008;
    step(1);
    soft_rst = 1'b0;
    check("srst_pc", 32'(pc), 32'h008);
    check("srst_iv", 32'(instr_valid), 32'h0);
    check("srst_running", 32'(running), 32'h1);
    step(0); check("srst_run_pc", 32'(pc), 32'h008);
    check("srst_cnt", 32'(cycle_cnt), cnt_exp());
    step(1); check("srst_inc", 32'(pc), 32'h009);

    // Halt, then branch attempts are ignored.
    soft_rst = 1'b1; soft_halt = 1'b1;
    step(1);
    soft_rst = 1'b0; soft_halt = 1'b0; br_en = 1'b1; boffset = 9'd4;
    check("halt_done", 32'(done), 32'h1);
    check("halt_pc", 32'(pc), 32'h009);
    check("halt_running", 32'(running), 32'h0);
    check("halt_iv", 32'(instr_valid), 32'h0);
    step(0); step(0);
    check("halt_hold_pc", 32'(pc), 32'h009);
    check("halt_hold_cnt", 32'(cycle_cnt), cnt_exp());
    br_en = 1'b0;

    // Restart from HALTED.
    start = 1'b1; start_addr = 10'h040;
    step(0); exp_cnt = 0;
    start = 1'b0;
    check("restart_pc", 32'(pc), 32'h040);
    check("restart_done", 32'(done), 32'h0);
    check("restart_cnt", 32'(cycle_cnt), 32'h0);
    step(0);
    step(1); step(1);
    check("rerun_pc", 32'(pc), 32'h042);
    start = 1'b1; start_addr = 10'h100;
    step(1); check("start_ign1", 32'(pc), 32'h043);
    step(1); check("start_ign2", 32'(pc), 32'h044);
    start = 1'b0;
    check("cnt_b", 32'(cycle_cnt), cnt_exp());

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_running", 32'(running), 32'h0);
    check("arst_iv", 32'(instr_valid), 32'h0);
    check("arst_cnt", 32'(cycle_cnt), 32'h0);
    #2 rst_n = 1'b1;

    // First START after reset is honoured; +1 wraps, -1 from 0 wraps.
    start = 1'b1; start_addr = 10'h3FF;
    step(0); exp_cnt = 0;
    start = 1'b0;
    check("post_rst_pc", 32'(pc), 32'h3FF);
    check("post_rst_running", 32'(running), 32'h1);
    step(0);
    step(1); check("inc_wrap", 32'(pc), 32'h000);
    br_en = 1'b1; bsign = 1'b1; boffset = 9'd1;
    step(1); check("dec_wrap", 32'(pc), 32'h3FF);
    check("cnt_c", 32'(cycle_cnt), cnt_exp());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
